// File: rtl/sseg_pkg.sv
// Shared constants for the display-scan receiver: segment patterns, digit count, FSM states.
package sseg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a} patterns as driven by the stopwatch.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [15:0][6:0] SEG_LUT = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic {SYNC = 1'b0, COLLECT = 1'b1} state_e;

endpackage

// File: rtl/sseg_decode.sv
// Maps an active-low 7-segment pattern back to its hex nibble; unknown patterns are flagged invalid.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] sseg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (sseg_i == SEG_LUT[i]) begin
                valid_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_rx.sv
// Display-scan receiver: debounces each anode dwell, decodes the digit and reassembles 4-digit frames.
module sseg_scan_rx
    import sseg_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        c_clk,
    input  logic        R_n,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        frame_bad,
    output logic        scan_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic [3:0]    an_q;
    logic [6:0]    sseg_q;
    logic          dp_q;
    logic [SW-1:0] stab_q, stab_d;
    logic          cap_q, cap_d;
    logic [TW-1:0] to_q, to_d;
    logic          expire;
    state_e        state_q, state_d;
    logic [1:0]    expd_q, expd_d;
    logic          bad_q, bad_d;
    logic [NUM_DIGITS-1:0][3:0] slot_q, slot_d, digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      sdp_q, sdp_d, dpm_q, dpm_d;
    logic          fv_q, fv_d, fb_q, fb_d, err_q, err_d, stale_q, stale_d;

    logic          one_hot, cap_ok, cap_multi, wr;
    logic [1:0]    k;
    logic          dec_vld;
    logic [3:0]    dec_nib;

    sseg_decode u_dec (
        .sseg_i   (sseg_q),
        .valid_o  (dec_vld),
        .nibble_o (dec_nib)
    );

    assign one_hot   = (an_q != 4'd0) && ((an_q & (an_q - 4'd1)) == 4'd0);
    assign cap_ok    = cap_q && one_hot;
    assign cap_multi = cap_q && (an_q != 4'd0) && !one_hot;

    always_comb begin
        case (an_q)
            4'b0010: k = 2'd1;
            4'b0100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: k = 2'd0;
        endcase
    end

    // The capture strobe is registered, so the timeout counter clears on the same edge the
    // strobe rises; a capture landing on the expiry edge therefore suppresses the expiry.
    always_comb begin
        stab_d = stab_q;
        if ({an, sseg, dp} != {an_q, sseg_q, dp_q}) stab_d = '0;
        else if (stab_q != SETTLE_C)                stab_d = stab_q + SW'(1);
        cap_d  = (stab_d == SETTLE_C) && (stab_q != SETTLE_C);

        to_d   = to_q;
        expire = 1'b0;
        if (cap_d && one_hot) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d   = to_q + TW'(1);
            expire = (to_q == TO_LAST);
        end
    end

    always_ff @(posedge c_clk or negedge R_n) begin
        if (!R_n) state_q <= SYNC;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (cap_ok && k == 2'd0) state_d = COLLECT;
            COLLECT: begin
                if (cap_multi)                                       state_d = SYNC;
                else if (cap_ok && k != expd_q && k != 2'd0)         state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
        if (expire) state_d = SYNC;
    end

    always_comb begin
        expd_d   = expd_q;
        bad_d    = bad_q;
        slot_d   = slot_q;
        sdp_d    = sdp_q;
        digits_d = digits_q;
        dpm_d    = dpm_q;
        fb_d     = fb_q;
        fv_d     = 1'b0;
        err_d    = cap_multi;
        wr       = 1'b0;
        if (cap_ok) begin
            case (state_q)
                SYNC: if (k == 2'd0) begin
                    wr     = 1'b1;
                    expd_d = 2'd1;
                end
                COLLECT: if (k == expd_q) begin
                    wr     = 1'b1;
                    expd_d = expd_q + 2'd1;
                    fv_d   = (k == 2'd3);
                end else begin
                    err_d = 1'b1;
                    if (k == 2'd0) begin
                        wr     = 1'b1;
                        expd_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
        // Slot 0 opens a frame, so it restarts the bad-pattern accumulation.
        if (wr) begin
            slot_d[k] = dec_nib;
            sdp_d[k]  = ~dp_q;
            bad_d     = ((k == 2'd0) ? 1'b0 : bad_q) | ~dec_vld;
        end
        if (fv_d) begin
            digits_d = slot_d;
            dpm_d    = sdp_d;
            fb_d     = bad_d;
        end
        stale_d = stale_q;
        if (fv_d)   stale_d = 1'b0;
        if (expire) stale_d = 1'b1;
    end

    always_ff @(posedge c_clk or negedge R_n) begin
        if (!R_n) begin
            an_q     <= '0;
            sseg_q   <= '0;
            dp_q     <= 1'b0;
            stab_q   <= '0;
            cap_q    <= 1'b0;
            to_q     <= '0;
            expd_q   <= '0;
            bad_q    <= 1'b0;
            slot_q   <= '0;
            sdp_q    <= '0;
            digits_q <= '0;
            dpm_q    <= '0;
            fv_q     <= 1'b0;
            fb_q     <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            an_q     <= an;
            sseg_q   <= sseg;
            dp_q     <= dp;
            stab_q   <= stab_d;
            cap_q    <= cap_d;
            to_q     <= to_d;
            expd_q   <= expd_d;
            bad_q    <= bad_d;
            slot_q   <= slot_d;
            sdp_q    <= sdp_d;
            digits_q <= digits_d;
            dpm_q    <= dpm_d;
            fv_q     <= fv_d;
            fb_q     <= fb_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign dp_mask     = dpm_q;
    assign frame_valid = fv_q;
    assign frame_bad   = fb_q;
    assign scan_err    = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_scan_rx.sv
// Directed bench for sseg_scan_rx: a table of full scans plus hand sequences for the timing corners.
module tb_sseg_scan_rx;

    localparam int TIMEOUT = 40;

    logic        c_clk, R_n;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        frame_valid, frame_bad, scan_err, stale;

    int checks = 0, errors = 0;
    int fv_cnt = 0, err_cnt = 0;

    sseg_scan_rx #(.SETTLE(2), .TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .R_n(R_n), .an(an), .sseg(sseg), .dp(dp),
        .digits(digits), .dp_mask(dp_mask), .frame_valid(frame_valid),
        .frame_bad(frame_bad), .scan_err(scan_err), .stale(stale)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0][6:0] pat;
        logic [3:0]      dpl;
        int              dwell;
        logic [15:0]     x_dig;
        logic [3:0]      x_dpm;
        logic            x_bad;
        int              x_fv;
        int              x_err;
    } vec_t;

    vec_t vec [7];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0][6:0] mkpat(input logic [15:0] v);
        logic [3:0][6:0] p;
        for (int i = 0; i < 4; i++) p[i] = seg7(v[4*i +: 4]);
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
        if (frame_valid === 1'b1) fv_cnt++;
        if (scan_err === 1'b1)    err_cnt++;
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; sseg = s; dp = d;
        repeat (n) tick();
    endtask

    task automatic scan(input logic [3:0][6:0] pat, input logic [3:0] dpl, input int dwell);
        for (int i = 0; i < 4; i++) show(4'b0001 << i, pat[i], dpl[i], dwell);
        repeat (3) tick();
    endtask

    task automatic clr();
        fv_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        logic [3:0][6:0] p;

        p = mkpat(16'h9999);
        p[1] = 7'h7F;
        vec[0] = '{mkpat(16'h1234), 4'b1011, 8, 16'h1234, 4'b0100, 1'b0, 1, 0};
        vec[1] = '{mkpat(16'h1234), 4'b1011, 8, 16'h1234, 4'b0100, 1'b0, 1, 0};
        vec[2] = '{mkpat(16'hABCD), 4'b1111, 3, 16'hABCD, 4'b0000, 1'b0, 1, 0};
        vec[3] = '{p,               4'b1111, 8, 16'h9909, 4'b0000, 1'b1, 1, 0};
        vec[4] = '{mkpat(16'hEF05), 4'b0000, 5, 16'hEF05, 4'b1111, 1'b0, 1, 0};
        vec[5] = '{mkpat(16'h1111), 4'b1111, 2, 16'hEF05, 4'b1111, 1'b0, 0, 1};
        vec[6] = '{mkpat(16'h8760), 4'b1110, 8, 16'h8760, 4'b0001, 1'b0, 1, 0};

        // Reset held with random inputs.
        R_n = 1'b0; an = '0; sseg = 7'h7F; dp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            an = 4'($urandom); sseg = 7'($urandom); dp = 1'($urandom);
            tick();
        end
        chk("rst_digits", digits, 0);
        chk("rst_dp_mask", dp_mask, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_bad", frame_bad, 0);
        chk("rst_scan_err", scan_err, 0);
        chk("rst_stale", stale, 0);

        R_n = 1'b1; an = '0; sseg = 7'h7F; dp = 1'b1;
        repeat (4) tick();
        clr();
        for (int i = 1; i < 4; i++) show(4'b0001 << i, seg7(4'(i)), 1'b1, 8);
        repeat (3) tick();
        chk("sync_no_frame", fv_cnt, 0);
        chk("sync_no_err", err_cnt, 0);

        for (int v = 0; v < 7; v++) begin
            clr();
            scan(vec[v].pat, vec[v].dpl, vec[v].dwell);
            chk($sformatf("vec%0d_digits", v), digits, vec[v].x_dig);
            chk($sformatf("vec%0d_dp_mask", v), dp_mask, vec[v].x_dpm);
            chk($sformatf("vec%0d_frame_bad", v), frame_bad, vec[v].x_bad);
            chk($sformatf("vec%0d_fv_count", v), fv_cnt, vec[v].x_fv);
            chk($sformatf("vec%0d_err_count", v), err_cnt, vec[v].x_err);
        end

        // One-cycle glitch right after digit 1 appears; the settled digit must still land.
        clr();
        p = mkpat(16'h1234);
        for (int i = 0; i < 4; i++) begin
            an = 4'b0001 << i; sseg = p[i]; dp = 1'b1;
            tick();
            if (i == 1) sseg = 7'h7F;
            tick();
            sseg = p[i];
            repeat (6) tick();
        end
        repeat (3) tick();
        chk("glitch_fv", fv_cnt, 1);
        chk("glitch_err", err_cnt, 0);
        chk("glitch_digits", digits, 16'h1234);

        // Anode skips digit 1.
        clr();
        show(4'b0001, seg7(4'h5), 1'b1, 8);
        show(4'b0100, seg7(4'h6), 1'b1, 8);
        show(4'b1000, seg7(4'h7), 1'b1, 8);
        repeat (3) tick();
        chk("skip_err", err_cnt, 1);
        chk("skip_fv", fv_cnt, 0);
        chk("skip_digits_held", digits, 16'h1234);

        // Multi-hot anode must drop back to SYNC, so digits 2/3 afterwards are ignored.
        clr();
        show(4'b0001, seg7(4'h1), 1'b1, 8);
        show(4'b0010, seg7(4'h2), 1'b1, 8);
        show(4'b0011, seg7(4'h8), 1'b1, 8);
        show(4'b0100, seg7(4'h3), 1'b1, 8);
        show(4'b1000, seg7(4'h4), 1'b1, 8);
        repeat (3) tick();
        chk("multi_err", err_cnt, 1);
        chk("multi_fv", fv_cnt, 0);

        // Digit 1 captured on exactly the cycle the timeout would expire.
        clr();
        show(4'b0001, seg7(4'h1), 1'b1, TIMEOUT);
        show(4'b0010, seg7(4'h2), 1'b1, 3);
        chk("expiry_capture_wins", stale, 0);
        repeat (5) tick();
        show(4'b0100, seg7(4'h3), 1'b1, 8);
        show(4'b1000, seg7(4'h4), 1'b1, 8);
        repeat (3) tick();
        chk("expiry_fv", fv_cnt, 1);
        chk("expiry_digits", digits, 16'h4321);

        // Scanning stops on digit 3 of a good frame.
        clr();
        show(4'b0001, seg7(4'hC), 1'b1, 8);
        show(4'b0010, seg7(4'h3), 1'b1, 8);
        show(4'b0100, seg7(4'hA), 1'b1, 8);
        show(4'b1000, seg7(4'h5), 1'b1, TIMEOUT + 2);
        chk("stale_before", stale, 0);
        chk("stale_frame", fv_cnt, 1);
        tick();
        chk("stale_at_timeout", stale, 1);
        repeat (5) tick();
        chk("stale_held", stale, 1);
        chk("stale_digits_held", digits, 16'h5A3C);
        clr();
        scan(mkpat(16'h0F1E), 4'b1111, 8);
        chk("stale_recover_fv", fv_cnt, 1);
        chk("stale_cleared", stale, 0);
        chk("stale_recover_digits", digits, 16'h0F1E);

        // Reset pulse mid-frame.
        clr();
        show(4'b0001, seg7(4'h7), 1'b1, 8);
        show(4'b0010, seg7(4'h7), 1'b1, 8);
        R_n = 1'b0;
        repeat (2) tick();
        chk("midrst_digits", digits, 0);
        chk("midrst_dp_mask", dp_mask, 0);
        chk("midrst_frame_bad", frame_bad, 0);
        R_n = 1'b1;
        show(4'b0100, seg7(4'h7), 1'b1, 8);
        show(4'b1000, seg7(4'h7), 1'b1, 8);
        repeat (3) tick();
        chk("midrst_partial_dropped", fv_cnt, 0);
        clr();
        scan(mkpat(16'h2468), 4'b1111, 8);
        chk("midrst_next_fv", fv_cnt, 1);
        chk("midrst_next_digits", digits, 16'h2468);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_rx.md
# sseg_scan_rx

Receiving end of the stopwatch display-scan bus. Samples the multiplexed anode/segment/decimal-point lines that the stopwatch state machine drives and decodes each 7-segment pattern back to a hex nibble. Reassembles complete 4-digit frames and flags scan-order, pattern and timeout errors. Used as a bench monitor/scoreboard front-end and as an on-chip loopback checker for the display path.

## Interface
- SETTLE, 2: consecutive cycles the registered an/sseg/dp must hold before a digit is captured (≥1).
- TIMEOUT, 1024: cycles without a capture before `stale` asserts (≥2).
- c_clk  in  1  single clock; an/sseg/dp are synchronous to it.
- R_n  in  1  reset, asynchronous, active-low.
- an  in  4  anode enables, active-high one-hot; an[k] selects digit k (k=0 least significant).
- sseg  in  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  in  1  decimal point, active-low.
- digits  out  16  last complete frame; digits[4k+3:4k] = digit k.
- dp_mask  out  4  bit k set if dp was low while digit k was captured.
- frame_valid  out  1  one-cycle pulse when digits/dp_mask update.
- frame_bad  out  1  qualifies frame_valid: ≥1 digit had an undecodable pattern.
- scan_err  out  1  one-cycle pulse on out-of-order or multi-hot anode.
- stale  out  1  level; no capture for TIMEOUT cycles.

## Operation
- Input stage: an, sseg, dp registered once (an_q, sseg_q, dp_q).
- Stability counter: reset to 0 whenever any of an_q/sseg_q/dp_q differs from the previous cycle; otherwise increments, saturating at SETTLE. A capture event fires in the one cycle the counter reaches SETTLE (once per dwell).
- At a capture: an_q == 0 → ignored. an_q multi-hot → scan_err, FSM to SYNC. One-hot index k → decode sseg_q; store nibble (4'h0 if invalid) and dp bit in shadow slot k, accumulate bad flag.
- Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). Any other pattern, blank 7F included, is invalid.
- FSM:
  - SYNC: waits for a capture with k=0. Then clears the bad flag, goes to COLLECT, expected=1.
  - COLLECT: a capture with k==expected stores the slot and increments expected. After k=3, shadow is copied to digits/dp_mask, frame_bad = accumulated bad, frame_valid pulses, and the FSM stays in COLLECT with expected=0.
  - COLLECT, k≠expected: scan_err pulses and the partial frame is discarded. If k==0, it is taken as a new frame start (expected=1); otherwise the FSM goes to SYNC.
- Timeout counter, width $clog2(TIMEOUT+1): cleared by any one-hot capture, saturates at TIMEOUT.
  - Reaching TIMEOUT sets `stale` and forces SYNC; digits/dp_mask are held.
  - `stale` clears on the next frame_valid.
  - A capture in the same cycle as expiry wins: the counter is cleared and `stale` is not set.
- Reset (R_n low, any time, mid-frame included): FSM=SYNC; digits=0, dp_mask=0, frame_valid=0, frame_bad=0, scan_err=0, stale=0; all counters and shadow slots 0.

## Timing
- Input change at cycle t reaches an_q at t+1. The capture fires at t+1+SETTLE if the input holds steady.
- frame_valid, digits and dp_mask update one cycle after the digit-3 capture (registered).
- scan_err is registered one cycle after the offending capture.
- Minimum dwell per digit for capture: SETTLE+1 cycles. Shorter dwells are silently ignored, and the next digit then arrives out of order.

## Structure
- Package sseg_pkg holds:
  - the 16 segment-pattern constants;
  - NUM_DIGITS=4;
  - the FSM state enum {SYNC, COLLECT}.
- Sub-module sseg_decode: combinational, sseg[6:0] → {valid, nibble[3:0]}. Instantiated once on sseg_q.
- Rest of the design, in the top: input registers, stability and timeout counters, FSM, shadow slots.

## Test plan
- Reset: hold R_n low with random inputs → all outputs 0. Release R_n → no frame_valid until a full 0→3 scan.
- Clean scan of C=16'h1234, dp low on digit 2, 8-cycle dwell → frame_valid once per scan with digits=16'h1234, dp_mask=4'b0100, frame_bad=0.
- sseg glitches for 1 cycle mid-dwell (SETTLE=2) → the digit is still captured correctly. Dwell of 2 cycles → digit dropped, scan_err, no frame.
- Anodes 0001→0100 → scan_err pulse, no frame. Anode 0011 → scan_err, FSM to SYNC.
- Digit 1 shows 7'h7F, others valid 9s → frame_valid with frame_bad=1, digits=16'h9909.
- Scanning stops after a good frame → stale=1 exactly TIMEOUT cycles after the last capture, digits held. Next full scan → frame_valid, stale=0. R_n pulsed mid-frame → partial frame discarded.
